pingpong_bank_ctrl: RTL and testbench

- Arbitrates the two IFM memory banks (ping-pong) that sit between a producing layer CU (e.g. a pooling CU writing its output IFM) and the consuming layer CU.
- Grants the write bank to the producer and hands filled banks to the consumer using the start/end handshake.
- Detects protocol violations.
- Replaces the local ifm_sel toggle logic in CUs when banks must be shared safely under back-pressure.

---
 rtl/pingpong_bank_ctrl.sv | 137 +++++++++++++
 tb/tb_pingpong_bank_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pingpong_bank_ctrl.sv
// Ping-pong IFM bank arbiter: hands the write bank to the producer and passes filled
// banks to the consumer in write order through the start/end handshake.
module pingpong_bank_ctrl #(
  parameter int ACK_TIMEOUT = 8,
  parameter int TO_WIDTH    = $clog2(ACK_TIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_written,
  output logic                end_to_previous,
  output logic                wr_sel,
  input  logic                end_from_next,
  output logic                start_to_next,
  output logic                rd_sel,
  output logic [1:0]          full_count,
  output logic                overflow_err,
  output logic                ack_err
);

  localparam logic [1:0] B_EMPTY    = 2'd0;
  localparam logic [1:0] B_FULL     = 2'd1;
  localparam logic [1:0] B_DRAINING = 2'd2;
  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT_LOW,
    R_WAIT_HIGH
  } rd_state_t;

  logic [1:0][1:0]     bank_q, bank_d;
  logic                wr_sel_q, wr_sel_d;
  logic                rd_sel_q, rd_sel_d;
  logic                start_q, start_d;
  logic                ovf_q, ovf_d;
  logic                ack_q, ack_d;
  rd_state_t           rd_state_q, rd_state_d;
  logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic [TO_WIDTH-1:0] to_cnt_inc;

  // The unused code 3 counts as EMPTY so a corrupted bank can never deadlock the producer.
  function automatic logic is_empty(input logic [1:0] s);
    return (s == B_EMPTY) || (s == 2'd3);
  endfunction

  assign to_cnt_inc = to_cnt_q + TO_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q     <= {B_EMPTY, B_EMPTY};
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      start_q    <= 1'b0;
      ovf_q      <= 1'b0;
      ack_q      <= 1'b0;
      rd_state_q <= R_IDLE;
      to_cnt_q   <= '0;
    end else begin
      bank_q     <= bank_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      start_q    <= start_d;
      ovf_q      <= ovf_d;
      ack_q      <= ack_d;
      rd_state_q <= rd_state_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // Write and read updates touch different banks: the producer only lands on an
  // EMPTY bank, the reader only moves a FULL or DRAINING one.
  always_comb begin
    bank_d[0]  = (bank_q[0] == 2'd3) ? B_EMPTY : bank_q[0];
    bank_d[1]  = (bank_q[1] == 2'd3) ? B_EMPTY : bank_q[1];
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    start_d    = 1'b0;
    ovf_d      = ovf_q;
    ack_d      = ack_q;
    rd_state_d = rd_state_q;
    to_cnt_d   = to_cnt_q;

    if (frame_written) begin
      if (is_empty(bank_q[wr_sel_q])) begin
        bank_d[wr_sel_q] = B_FULL;
        wr_sel_d         = ~wr_sel_q;
      end else begin
        ovf_d = 1'b1;
      end
    end

    case (rd_state_q)
      R_IDLE: begin
        if (bank_q[rd_sel_q] == B_FULL && end_from_next) begin
          start_d          = 1'b1;
          bank_d[rd_sel_q] = B_DRAINING;
          to_cnt_d         = '0;
          rd_state_d       = R_WAIT_LOW;
        end
      end
      R_WAIT_LOW: begin
        if (!end_from_next) begin
          to_cnt_d   = '0;
          rd_state_d = R_WAIT_HIGH;
        end else if (to_cnt_inc == TO_LIMIT) begin
          // Consumer never acknowledged; hand the bank back so start is reissued.
          ack_d            = 1'b1;
          bank_d[rd_sel_q] = B_FULL;
          to_cnt_d         = '0;
          rd_state_d       = R_IDLE;
        end else begin
          to_cnt_d = to_cnt_inc;
        end
      end
      R_WAIT_HIGH: begin
        if (end_from_next) begin
          bank_d[rd_sel_q] = B_EMPTY;
          rd_sel_d         = ~rd_sel_q;
          rd_state_d       = R_IDLE;
        end
      end
      default: begin
        to_cnt_d   = '0;
        rd_state_d = R_IDLE;
      end
    endcase
  end

  assign end_to_previous = is_empty(bank_q[wr_sel_q]);
  assign wr_sel          = wr_sel_q;
  assign rd_sel          = rd_sel_q;
  assign start_to_next   = start_q;
  assign overflow_err    = ovf_q;
  assign ack_err         = ack_q;
  assign full_count      = {1'b0, bank_q[0] == B_FULL} + {1'b0, bank_q[1] == B_FULL};

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// Directed bench for pingpong_bank_ctrl: single frame, back-pressure, release ordering,
// simultaneous write/release, reset mid-drain and ack timeout.
module tb_pingpong_bank_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_written;
  logic       end_to_previous;
  logic       wr_sel;
  logic       end_from_next;
  logic       start_to_next;
  logic       rd_sel;
  logic [1:0] full_count;
  logic       overflow_err;
  logic       ack_err;

  int compared   = 0;
  int mismatched = 0;

  pingpong_bank_ctrl #(.ACK_TIMEOUT(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .frame_written   (frame_written),
    .end_to_previous (end_to_previous),
    .wr_sel          (wr_sel),
    .end_from_next   (end_from_next),
    .start_to_next   (start_to_next),
    .rd_sel          (rd_sel),
    .full_count      (full_count),
    .overflow_err    (overflow_err),
    .ack_err         (ack_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive inputs for the current cycle, then advance to just after the next edge.
  task automatic applyStimulus(input logic fw, input logic efn);
    frame_written = fw;
    end_from_next = efn;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    reset = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".etp"},   int'(end_to_previous), 1);
    checkOutput({tag, ".fc"},    int'(full_count),      0);
    checkOutput({tag, ".wr"},    int'(wr_sel),          0);
    checkOutput({tag, ".rd"},    int'(rd_sel),          0);
    checkOutput({tag, ".start"}, int'(start_to_next),   0);
    checkOutput({tag, ".ovf"},   int'(overflow_err),    0);
    checkOutput({tag, ".ack"},   int'(ack_err),         0);
  endtask

  initial begin
    reset         = 1'b1;
    frame_written = 1'b0;
    end_from_next = 1'b1;
    applyReset();
    checkResetValues("rst");

    // Single frame into bank0
    applyStimulus(1'b1, 1'b1);
    checkOutput("sf.fc1",    int'(full_count),      1);
    checkOutput("sf.wr1",    int'(wr_sel),          1);
    checkOutput("sf.start1", int'(start_to_next),   0);
    checkOutput("sf.etp1",   int'(end_to_previous), 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("sf.start2", int'(start_to_next),   1);
    checkOutput("sf.rd2",    int'(rd_sel),          0);
    checkOutput("sf.fc2",    int'(full_count),      0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("sf.start3", int'(start_to_next),   0);
    checkOutput("sf.etp3",   int'(end_to_previous), 1);

    // Back-pressure: bank1 fills while bank0 drains, then a third frame overflows
    applyStimulus(1'b1, 1'b0);
    checkOutput("bp.fc",   int'(full_count),      1);
    checkOutput("bp.wr",   int'(wr_sel),          0);
    checkOutput("bp.etp",  int'(end_to_previous), 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("ov.ovf",  int'(overflow_err),    1);
    checkOutput("ov.wr",   int'(wr_sel),          0);
    checkOutput("ov.fc",   int'(full_count),      1);

    // Release bank0, bank1 follows two cycles after release
    applyStimulus(1'b0, 1'b1);
    checkOutput("rel.rd",    int'(rd_sel),          1);
    checkOutput("rel.etp",   int'(end_to_previous), 1);
    checkOutput("rel.fc",    int'(full_count),      1);
    checkOutput("rel.start", int'(start_to_next),   0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("rel.start2", int'(start_to_next),  1);
    checkOutput("rel.rd2",    int'(rd_sel),         1);
    checkOutput("rel.fc2",    int'(full_count),     0);

    // Simultaneous bank1 write and bank0 release
    applyReset();
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("sim.start0", int'(start_to_next), 1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("sim.fc",  int'(full_count),      1);
    checkOutput("sim.wr",  int'(wr_sel),          0);
    checkOutput("sim.rd",  int'(rd_sel),          1);
    checkOutput("sim.etp", int'(end_to_previous), 1);
    checkOutput("sim.ovf", int'(overflow_err),    0);
    checkOutput("sim.ack", int'(ack_err),         0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("sim.start", int'(start_to_next), 1);
    checkOutput("sim.rd2",   int'(rd_sel),        1);

    // Reset while bank1 sits in R_WAIT_HIGH with bank0 full and overflow raised
    applyStimulus(1'b1, 1'b0);
    checkOutput("rmd.fc",  int'(full_count),      1);
    checkOutput("rmd.etp", int'(end_to_previous), 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rmd.ovf", int'(overflow_err),    1);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    reset = 1'b0;
    checkResetValues("rmd");
    applyStimulus(1'b0, 1'b0);
    checkOutput("rmd.start_after", int'(start_to_next), 0);

    // Ack timeout: consumer never drops end_from_next
    applyReset();
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("to.start0", int'(start_to_next), 1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("to.ack7",   int'(ack_err),       0);
    checkOutput("to.fc7",    int'(full_count),    0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("to.ack8",   int'(ack_err),       1);
    checkOutput("to.fc8",    int'(full_count),    1);
    checkOutput("to.start8", int'(start_to_next), 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("to.start9", int'(start_to_next), 1);
    checkOutput("to.rd9",    int'(rd_sel),        0);
    checkOutput("to.fc9",    int'(full_count),    0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
